// File: rtl/tagged_instr_encoder_if.sv
// Request/response bundle between the instruction front-end, the tagged-word encoder and its consumers.
// The slave side is the encoder; the master side drives requests and consumes words.
interface tagged_instr_encoder_if #(
    parameter int REG_W  = 5,
    parameter int ADDR_W = 10
);
    localparam int PW = (3 * REG_W > 3 + ADDR_W) ? 3 * REG_W : 3 + ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [REG_W-1:0]  in_rd;
    logic [REG_W-1:0]  in_r1;
    logic [REG_W-1:0]  in_r2;
    logic [2:0]        in_cond;
    logic [ADDR_W-1:0] in_addr;
    logic              out_valid;
    logic              out_ready;
    logic [PW+1:0]     out_data;
    logic [7:0]        err_cnt;

    modport master (
        output in_valid, in_kind, in_rd, in_r1, in_r2, in_cond, in_addr, out_ready,
        input  in_ready, out_valid, out_data, err_cnt
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_r1, in_r2, in_cond, in_addr, out_ready,
        output in_ready, out_valid, out_data, err_cnt
    );
endinterface

// File: rtl/tagged_instr_encoder.sv
// Packs Add/Jmp/Bcc fields into tagged Instr words through a 2-entry buffer; illegal selects are dropped and counted.
// Latency 1 cycle; in_ready = count<2 from registered state only, so consumer stalls never reach the front-end combinationally.
module tagged_instr_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count
);
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_pop   = pop && (cnt != 2'd0);
    assign do_push  = push && ((cnt != 2'd2) || do_pop);
    assign head_dat = slot0;
    assign count    = cnt;

    // slot0 is the head and keeps the last word when the buffer drains
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= push_dat;
                    else             slot1 <= push_dat;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd2) slot0 <= slot1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= push_dat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module tagged_instr_encoder #(
    parameter int REG_W  = 5,
    parameter int ADDR_W = 10
) (
    input  logic clk,
    input  logic rst,
    tagged_instr_encoder_if.slave bus
);
    localparam int PW = (3 * REG_W > 3 + ADDR_W) ? 3 * REG_W : 3 + ADDR_W;

    typedef enum logic [1:0] {
        KIND_ADD = 2'b00,
        KIND_JMP = 2'b01,
        KIND_BCC = 2'b10,
        KIND_ILL = 2'b11
    } kind_t;

    typedef struct packed {
        logic [1:0]    tag;
        logic [PW-1:0] payload;
    } instr_t;

    kind_t      kind;
    instr_t     word;
    instr_t     head;
    logic [1:0] count;
    logic       accept;
    logic       push;
    logic       pop;
    logic [7:0] err_q;

    assign kind   = kind_t'(bus.in_kind);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && (kind != KIND_ILL);
    assign pop    = bus.out_valid && bus.out_ready;

    // Members are right-justified; the tag value equals the member select
    always_comb begin
        word = '0;
        case (kind)
            KIND_ADD: begin
                word.tag     = KIND_ADD;
                word.payload = PW'({bus.in_rd, bus.in_r1, bus.in_r2});
            end
            KIND_JMP: begin
                word.tag     = KIND_JMP;
                word.payload = PW'(bus.in_addr);
            end
            KIND_BCC: begin
                word.tag     = KIND_BCC;
                word.payload = PW'({bus.in_cond, bus.in_addr});
            end
            default: word = '0;
        endcase
    end

    tagged_instr_fifo2 #(.W(PW + 2)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (word),
        .pop      (pop),
        .head_dat (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (accept && (kind == KIND_ILL) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.in_ready  = (count != 2'd2) && !rst;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_tagged_instr_encoder.sv
module tb_tagged_instr_encoder;
    localparam int REG_W  = 5;
    localparam int ADDR_W = 10;
    localparam int PW     = 15;

    typedef logic [PW+1:0] word_t;

    typedef struct {
        logic [1:0]        kind;
        logic [REG_W-1:0]  rd, r1, r2;
        logic [2:0]        cond;
        logic [ADDR_W-1:0] addr;
        word_t             exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tagged_instr_encoder_if #(.REG_W(REG_W), .ADDR_W(ADDR_W)) bus ();

    tagged_instr_encoder #(.REG_W(REG_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    total = 0;
    int    bad   = 0;
    word_t mq[$];
    word_t m_last = '0;
    int    m_err  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference encoding from the member layout, as plain arithmetic
    function automatic word_t ref_word(input int kind, input int rd, input int r1, input int r2,
                                       input int cond, input int addr);
        int p;
        case (kind)
            0:       p = rd * (1 << (2 * REG_W)) + r1 * (1 << REG_W) + r2;
            1:       p = addr;
            default: p = cond * (1 << ADDR_W) + addr;
        endcase
        return word_t'(kind * (1 << PW) + p);
    endfunction

    task automatic step(input bit v, input logic [1:0] k, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] r1, input logic [REG_W-1:0] r2,
                        input logic [2:0] cond, input logic [ADDR_W-1:0] addr, input bit ordy);
        bit acc, popd;
        bus.in_valid  = v;
        bus.in_kind   = k;
        bus.in_rd     = rd;
        bus.in_r1     = r1;
        bus.in_r2     = r2;
        bus.in_cond   = cond;
        bus.in_addr   = addr;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        chk("out_data", 32'(bus.out_data), 32'((mq.size() != 0) ? mq[0] : m_last));
        chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
        acc  = v && (mq.size() < 2);
        popd = (mq.size() != 0) && ordy;
        if (popd) m_last = mq.pop_front();
        if (acc) begin
            if (k == 2'd3) begin
                if (m_err < 255) m_err++;
            end else begin
                mq.push_back(ref_word(int'(k), int'(rd), int'(r1), int'(r2), int'(cond), int'(addr)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 2'd0, '0, '0, '0, '0, '0, ordy);
    endtask

    task automatic add(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] r1,
                       input logic [REG_W-1:0] r2, input bit ordy);
        step(1'b1, 2'd0, rd, r1, r2, 3'd0, '0, ordy);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_kind  = 2'd0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        mq.delete();
        m_last = '0;
        m_err  = 0;
        rst    = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'd0, 5'd3,  5'd1,  5'd2,  3'd0, 10'h000, 17'h00C22};
        vecs[1] = '{2'd1, 5'd9,  5'd4,  5'd7,  3'd6, 10'h155, 17'h08155};
        vecs[2] = '{2'd2, 5'd1,  5'd1,  5'd1,  3'd5, 10'h3FF, 17'h117FF};
        vecs[3] = '{2'd0, 5'd31, 5'd31, 5'd31, 3'd7, 10'h3FF, 17'h07FFF};
        vecs[4] = '{2'd1, 5'd31, 5'd31, 5'd31, 3'd7, 10'h3FF, 17'h083FF};
        vecs[5] = '{2'd2, 5'd31, 5'd0,  5'd31, 3'd7, 10'h000, 17'h11C00};
        vecs[6] = '{2'd0, 5'd0,  5'd0,  5'd1,  3'd0, 10'h000, 17'h00001};
        vecs[7] = '{2'd2, 5'd0,  5'd0,  5'd0,  3'd0, 10'h001, 17'h10001};
        vecs[8] = '{2'd0, 5'd16, 5'd0,  5'd0,  3'd7, 10'h2AA, 17'h04000};

        bus.in_valid  = 1'b0;
        bus.in_kind   = 2'd0;
        bus.in_rd     = '0;
        bus.in_r1     = '0;
        bus.in_r2     = '0;
        bus.in_cond   = '0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // Encode table, back to back with the consumer always ready
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].kind, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].cond, vecs[i].addr, 1'b1);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp));
        end
        idle(1'b1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_last", 32'(bus.out_data), 32'h04000);

        // Back-pressure: three requests, two accepted
        add(5'd1, 5'd1, 5'd1, 1'b0);
        add(5'd2, 5'd2, 5'd2, 1'b0);
        chk("bp_stall", 32'(bus.in_ready), 32'd0);
        add(5'd3, 5'd3, 5'd3, 1'b0);
        add(5'd3, 5'd3, 5'd3, 1'b1);
        chk("bp_reopen", 32'(bus.in_ready), 32'd1);
        add(5'd3, 5'd3, 5'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_last", 32'(bus.out_data), 32'h00C63);

        // Illegal selects interleaved with legal ones
        step(1'b1, 2'd3, '0, '0, '0, '0, '0, 1'b1);
        add(5'd4, 5'd5, 5'd6, 1'b1);
        step(1'b1, 2'd3, '0, '0, '0, '0, '0, 1'b1);
        step(1'b1, 2'd1, '0, '0, '0, '0, 10'h0AB, 1'b1);
        step(1'b1, 2'd3, '0, '0, '0, '0, '0, 1'b1);
        chk("ill_cnt3", 32'(bus.err_cnt), 32'd3);
        idle(1'b1);
        for (int i = 0; i < 253; i++) step(1'b1, 2'd3, '0, '0, '0, '0, '0, 1'b1);
        chk("ill_255", 32'(bus.err_cnt), 32'd255);
        step(1'b1, 2'd3, '0, '0, '0, '0, '0, 1'b1);
        chk("ill_sat", 32'(bus.err_cnt), 32'd255);

        // Concurrent push and pop at count 1
        add(5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            add(5'(i + 1), 5'(i), 5'(i + 2), 1'b1);
            chk("cnt1_valid", 32'(bus.out_valid & bus.in_ready), 32'd1);
        end
        idle(1'b1);
        idle(1'b1);

        // Reset mid-stream with a request pending
        add(5'd7, 5'd7, 5'd7, 1'b0);
        add(5'd8, 5'd8, 5'd8, 1'b0);
        do_reset();
        add(5'd3, 5'd1, 5'd2, 1'b1);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'h00C22);
        idle(1'b1);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 2'($urandom % 4), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 10'($urandom), ($urandom % 3) != 0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("final_empty", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tagged_instr_encoder.md
# tagged_instr_encoder

Constructs packed `Instr` tagged-union words (members `Add`, `Jmp`, `Bcc`) from discrete instruction fields and streams them to downstream consumers, which then match on them with `case ... matches` / `if (... matches tagged ...)`. It is the producing end of the tagged-instruction interface. A valid/ready input, a 2-entry output buffer and a valid/ready output decouple front-end issue from consumer back-pressure. Illegal member selects are consumed, dropped and counted.

## Interface
- `REG_W`, default 5: register-index width.
- `ADDR_W`, default 10: jump target width.
- Derived `PW` = max(3*REG_W, 3+ADDR_W): payload width (15 at defaults). Output word width is `PW+2`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_kind`  in  2  member select: 0 = `Add`, 1 = `Jmp`, 2 = `Bcc`, 3 = illegal.
- `in_rd`, `in_r1`, `in_r2`  in  REG_W each  `Add` fields.
- `in_cond`  in  3  `Bcc` condition.
- `in_addr`  in  ADDR_W  `Jmp`/`Bcc` target.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_data`  out  PW+2  tagged word: bits [PW+1:PW] = tag, bits [PW-1:0] = payload.
- `err_cnt`  out  8  illegal requests dropped; saturates at 255.

## Operation
- Tag encoding: `Add` = 2'b00, `Jmp` = 2'b01, `Bcc` = 2'b10. Tag 2'b11 is never emitted.
- Payload packing:
  - All members are right-justified. Unused upper payload bits are 0.
  - `Add` = {rd, r1, r2}, with `r2` in the LSBs.
  - `Jmp` = {addr}.
  - `Bcc` = {cond, addr}.
  - Fields not belonging to the selected member are ignored.
- Buffer: 2-entry FIFO of encoded words with an occupancy count of 0..2.
  - Encoding happens combinationally before the write, so the buffer holds finished words.
- `in_ready` = (count < 2) && !rst. It depends only on registered state, never on `out_ready`.
- Legal accept: the word is pushed.
- Illegal accept (`in_kind` = 3):
  - The request is consumed and nothing is pushed.
  - `err_cnt` increments unless it is already 255.
- `out_valid` = (count != 0). `out_data` = head entry; when empty, `out_data` holds its last value (0 after reset).
- Pop occurs on `out_valid && out_ready`.
- Simultaneous push and pop:
  - count 1: count stays 1; the new word becomes head on the next cycle.
  - count 2: push is impossible because `in_ready` = 0; the pop alone takes count to 1.
  - count 0: no pop occurs, because `out_valid` = 0.
- Ordering is strict FIFO. No word is dropped or duplicated under any `out_ready` pattern.
- Reset values: count 0, `out_valid` 0, `out_data` 0, `err_cnt` 0, `in_ready` 0 while `rst` is high and 1 on the first cycle after.
- Reset mid-stream discards all buffered words. Any handshake in the reset cycle is ignored.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible on `out_data` with `out_valid` = 1 after edge N, if the buffer was empty.
- Sustained throughput is 1 word per cycle while `out_ready` = 1.
- With `out_ready` held low, exactly 2 words are accepted. `in_ready` falls in the cycle after the second accept.
- `err_cnt` updates at the edge that accepts the illegal request.
- Outputs are registered or derived from registered state only. There is no combinational path from `out_ready` to `in_ready`.

## Test plan
- **Add encode:** with defaults, Add rd=3, r1=1, r2=2 into an empty buffer with `out_ready` = 1 → `out_data` = 17'h00C22 one cycle later, `out_valid` high for exactly 1 cycle.
- **Jmp/Bcc encode:** Jmp addr=10'h155 → 17'h08155. Then Bcc cond=5, addr=10'h3FF → 17'h117FF. Both appear in order on consecutive cycles.
- **Back-pressure:** `out_ready` = 0 while issuing 3 Adds each cycle → only 2 accepted and `in_ready` = 0 from the third cycle. Release `out_ready` → words emerge in order, `in_ready` reasserts after the first pop, and the third request is then accepted.
- **Illegal select:** 3 requests with `in_kind` = 3 interleaved with 2 legal ones → `err_cnt` = 3, exactly 2 output words. Preload `err_cnt` to 255 via 255 illegal requests, then send 1 more → `err_cnt` stays 255.
- **Push/pop at count 1:** hold count at 1 with concurrent accept and pop for 10 cycles → count stays 1, all 10 words delivered in order.
- **Reset mid-stream:** fill 2 entries, assert `rst` for 1 cycle with `in_valid` = 1 → `out_valid` = 0, `err_cnt` = 0, `out_data` = 0, no word emitted. The first post-reset request then has 1-cycle latency.
